// File: rtl/framebuffer_sram_reader_pkg.sv
// Shared video definitions for the framebuffer SRAM reader.
`ifndef RGB_SIZE
`define RGB_SIZE 16
`endif

package framebuffer_sram_reader_pkg;

  localparam int unsigned RGB_W         = `RGB_SIZE;
  localparam int unsigned H_DISPLAY_DEF = 320;
  localparam int unsigned V_DISPLAY_DEF = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_rd_state_t;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_sram_reader_if.sv
// Avalon-MM read bus plus the outgoing pixel stream.
interface framebuffer_sram_reader_if
  import framebuffer_sram_reader_pkg::*;
#(
  parameter int unsigned AVN_AW = 18,
  parameter int unsigned AVN_DW = 16
);

  logic                  avn_read;
  logic [AVN_AW-1:0]     avn_address;
  logic [AVN_DW/8-1:0]   avn_byteenable;
  logic [AVN_DW-1:0]     avn_readdata;
  logic                  avn_readdatavalid;
  logic                  avn_waitrequest;
  logic [RGB_W-1:0]      pix_rgb;
  logic                  pix_vld;
  logic                  pix_rdy;
  logic                  pix_sof;
  logic                  pix_eol;

  modport master (
    output avn_read, avn_address, avn_byteenable,
    input  avn_readdata, avn_readdatavalid, avn_waitrequest,
    output pix_rgb, pix_vld, pix_sof, pix_eol,
    input  pix_rdy
  );

  modport slave (
    input  avn_read, avn_address, avn_byteenable,
    output avn_readdata, avn_readdatavalid, avn_waitrequest,
    input  pix_rgb, pix_vld, pix_sof, pix_eol,
    output pix_rdy
  );

endinterface

// File: rtl/framebuffer_sram_reader_sync_fifo.sv
// Single-clock show-ahead FIFO; head word is visible whenever not empty.
module framebuffer_sram_reader_sync_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;

endmodule

// File: rtl/framebuffer_sram_reader.sv
// Fetches whole frames from SRAM in raster order and streams them as pixels.
module framebuffer_sram_reader
  import framebuffer_sram_reader_pkg::*;
#(
  parameter int unsigned AVN_AW    = 18,
  parameter int unsigned AVN_DW    = 16,
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned BUF_SIZE  = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       enable,
  output logic                       busy,
  framebuffer_sram_reader_if.master  bus
);

  localparam int unsigned NPIX = H_DISPLAY * V_DISPLAY;
  localparam int unsigned IW   = cnt_w(NPIX);
  localparam int unsigned CW   = cnt_w(BUF_SIZE + 1);
  localparam int unsigned HW   = cnt_w(H_DISPLAY);
  localparam int unsigned VW   = cnt_w(V_DISPLAY);

  if (64'(BASE_ADDR) + 64'(NPIX) > (64'(1) << AVN_AW)) begin : g_range_err
    $error("framebuffer does not fit in the Avalon address space");
  end
  if (BUF_SIZE < 4 || (BUF_SIZE & (BUF_SIZE - 1)) != 0) begin : g_buf_err
    $error("BUF_SIZE must be a power of two and at least 4");
  end

  fb_rd_state_t      state_q, state_d;
  logic              read_q, read_d;
  logic [AVN_AW-1:0] addr_q, addr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [HW-1:0]     hc_q, hc_d;
  logic [VW-1:0]     vc_q, vc_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          vld, accept, pop, last_pop;

  assign vld      = !fifo_empty;
  assign accept   = read_q && !bus.avn_waitrequest;
  assign pop      = vld && bus.pix_rdy;
  assign last_pop = pop && (hc_q == HW'(H_DISPLAY - 1)) && (vc_q == VW'(V_DISPLAY - 1));

  framebuffer_sram_reader_sync_fifo #(
    .DW    (RGB_W),
    .DEPTH (BUF_SIZE)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (bus.avn_readdatavalid),
    .wr_data (bus.avn_readdata[RGB_W-1:0]),
    .rd_en   (pop),
    .rd_data (bus.pix_rgb),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, request issue, credit and raster counter updates.
  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    hc_d     = hc_q;
    vc_d     = vc_q;

    unique case ({accept, pop})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase

    if (pop) begin
      if (hc_q == HW'(H_DISPLAY - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == VW'(V_DISPLAY - 1)) ? '0 : vc_q + VW'(1);
      end else begin
        hc_d = hc_q + HW'(1);
      end
    end

    if (accept) begin
      if (idx_q == IW'(NPIX - 1)) begin
        idx_d = '0;
        addr_d = AVN_AW'(BASE_ADDR);
      end else begin
        idx_d  = idx_q + IW'(1);
        addr_d = AVN_AW'(BASE_ADDR) + AVN_AW'(idx_q) + AVN_AW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          idx_d   = '0;
          addr_d  = AVN_AW'(BASE_ADDR);
          hc_d    = '0;
          vc_d    = '0;
        end
      end
      FETCH: begin
        if (accept && idx_q == IW'(NPIX - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = enable ? FETCH : IDLE;
          idx_d   = '0;
          addr_d  = AVN_AW'(BASE_ADDR);
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled request must be held unchanged until accepted.
    if (read_q && bus.avn_waitrequest) read_d = 1'b1;
    else read_d = (state_d == FETCH) && (credit_d < CW'(BUF_SIZE));
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      addr_q   <= AVN_AW'(BASE_ADDR);
      idx_q    <= '0;
      credit_q <= '0;
      hc_q     <= '0;
      vc_q     <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
    end
  end

  assign bus.avn_read       = read_q;
  assign bus.avn_address    = addr_q;
  assign bus.avn_byteenable = '1;
  assign bus.pix_vld        = vld;
  assign bus.pix_sof        = vld && (hc_q == '0) && (vc_q == '0);
  assign bus.pix_eol        = vld && (hc_q == HW'(H_DISPLAY - 1));
  assign busy               = (state_q != IDLE);

  // Credit accounting must keep the FIFO from overflowing.
  a_no_overflow: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    !(bus.avn_readdatavalid && fifo_full));
  a_credit_covers_fifo: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    credit_q >= fifo_count);

endmodule

// File: tb/tb_framebuffer_sram_reader.sv
// Self-checking bench: Avalon slave model, pixel sink and scoreboard.
module tb_framebuffer_sram_reader;
  import framebuffer_sram_reader_pkg::*;

  localparam int unsigned AW   = 18;
  localparam int unsigned DW   = 16;
  localparam int unsigned H    = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned NPIX = H * V;
  localparam int unsigned BASE = 32'h100;
  localparam int unsigned BUF  = 4;

  typedef struct { logic [RGB_W-1:0] rgb; logic sof; logic eol; } exp_t;
  typedef struct { logic [DW-1:0] data; int due; } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;

  framebuffer_sram_reader_if #(.AVN_AW(AW), .AVN_DW(DW)) bus ();

  framebuffer_sram_reader #(
    .AVN_AW(AW), .AVN_DW(DW), .H_DISPLAY(H), .V_DISPLAY(V),
    .BASE_ADDR(BASE), .BUF_SIZE(BUF)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .enable    (enable),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned wait_pct = 0, rdy_pct = 100, lat_min = 1, lat_max = 1;
  exp_t  sb[$];
  resp_t resp_q[$];
  logic [AW-1:0] acc_log[$];
  int n_acc = 0, n_pix = 0, n_sof = 0, n_eol = 0, n_stall = 0;
  int exp_idx = 0, last_idx = 0, last_acc_cyc = 0, max_gap = 0, last_due = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503;
    return t[DW-1:0] ^ 16'h5A3C;
  endfunction

  // Avalon slave model and pixel sink, all driven/sampled on the falling edge.
  initial begin : monitor
    bit prev_stall, prev_hold, w;
    logic [AW-1:0] prev_addr, exp_a;
    logic [RGB_W-1:0] hold_rgb;
    logic hold_sof, hold_eol;
    exp_t e;
    resp_t r;
    int due, gap;
    prev_stall = 0; prev_hold = 0; prev_addr = '0;
    hold_rgb = '0; hold_sof = 0; hold_eol = 0;
    bus.avn_readdata = '0; bus.avn_readdatavalid = 0; bus.avn_waitrequest = 0; bus.pix_rdy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete(); resp_q.delete();
        exp_idx = 0; last_idx = 0; last_due = 0; prev_stall = 0; prev_hold = 0;
        bus.avn_readdatavalid = 0; bus.avn_waitrequest = 0; bus.avn_readdata = '0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (bus.avn_read !== 1'b1 || bus.avn_address !== prev_addr) begin
            errors++;
            $display("FAIL stall_hold read=%b addr=%h required read=1 addr=%h", bus.avn_read, bus.avn_address, prev_addr);
          end
        end
        if (prev_hold) begin
          checks++;
          if (bus.pix_vld !== 1'b1 || bus.pix_rgb !== hold_rgb || bus.pix_sof !== hold_sof || bus.pix_eol !== hold_eol) begin
            errors++;
            $display("FAIL pix_hold vld=%b rgb=%h sof=%b eol=%b required 1 %h %b %b", bus.pix_vld, bus.pix_rgb, bus.pix_sof, bus.pix_eol, hold_rgb, hold_sof, hold_eol);
          end
        end
        bus.pix_rdy = ($urandom_range(0, 99) < rdy_pct);
        if (bus.pix_vld === 1'b1 && bus.pix_rdy) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected rgb=%h required no pixel", bus.pix_rgb);
          end else begin
            e = sb.pop_front();
            if (bus.pix_rgb !== e.rgb || bus.pix_sof !== e.sof || bus.pix_eol !== e.eol) begin
              errors++;
              $display("FAIL pixel rgb=%h sof=%b eol=%b required rgb=%h sof=%b eol=%b", bus.pix_rgb, bus.pix_sof, bus.pix_eol, e.rgb, e.sof, e.eol);
            end
          end
          n_pix++;
          if (bus.pix_sof === 1'b1) n_sof++;
          if (bus.pix_eol === 1'b1) n_eol++;
        end
        prev_hold = (bus.pix_vld === 1'b1) && !bus.pix_rdy;
        hold_rgb = bus.pix_rgb; hold_sof = bus.pix_sof; hold_eol = bus.pix_eol;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
          r = resp_q.pop_front();
          bus.avn_readdatavalid = 1;
          bus.avn_readdata = r.data;
        end else begin
          bus.avn_readdatavalid = 0;
          bus.avn_readdata = 16'($urandom);
        end
        w = ($urandom_range(0, 99) < wait_pct);
        bus.avn_waitrequest = w;
        prev_stall = (bus.avn_read === 1'b1) && w;
        prev_addr = bus.avn_address;
        if (prev_stall) n_stall++;
        if (bus.avn_read === 1'b1 && !w) begin
          exp_a = AW'(BASE + exp_idx);
          checks++;
          if (bus.avn_address !== exp_a) begin
            errors++;
            $display("FAIL req_addr addr=%h required %h", bus.avn_address, exp_a);
          end
          acc_log.push_back(bus.avn_address);
          n_acc++;
          if (exp_idx == 0 && last_idx == NPIX - 1) begin
            gap = cyc - last_acc_cyc;
            if (gap > max_gap) max_gap = gap;
          end
          last_idx = exp_idx;
          last_acc_cyc = cyc;
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          resp_q.push_back('{mem_word(bus.avn_address), due});
          sb.push_back('{mem_word(exp_a), exp_idx == 0, (exp_idx % H) == H - 1});
          exp_idx = (exp_idx + 1) % NPIX;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    checks++; if (bus.avn_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b required 0", bus.avn_read); end
    checks++; if (bus.avn_address !== AW'(BASE)) begin errors++; $display("FAIL reset_addr got=%h required %h", bus.avn_address, AW'(BASE)); end
    checks++; if (bus.avn_byteenable !== 2'b11) begin errors++; $display("FAIL reset_be got=%b required 11", bus.avn_byteenable); end
    checks++; if (bus.pix_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b required 0", bus.pix_vld); end
    checks++; if (bus.pix_sof !== 1'b0 || bus.pix_eol !== 1'b0) begin errors++; $display("FAIL reset_sof_eol got=%b%b required 00", bus.pix_sof, bus.pix_eol); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required 0", busy); end
  endtask

  task automatic test_single_frame();
    int a0, p0, s0, e0, k;
    wait_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    acc_log.delete();
    a0 = n_acc; p0 = n_pix; s0 = n_sof; e0 = n_eol;
    @(negedge clk); enable = 1;
    @(negedge clk); enable = 0;
    k = 0; while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b required 0", busy); end
    checks++; if (n_acc - a0 != int'(NPIX)) begin errors++; $display("FAIL single_reads got=%0d required %0d", n_acc - a0, NPIX); end
    for (int i = 0; i < int'(NPIX) && i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i] !== AW'(BASE + i)) begin errors++; $display("FAIL single_addr_%0d got=%h required %h", i, acc_log[i], AW'(BASE + i)); end
    end
    checks++; if (n_pix - p0 != int'(NPIX)) begin errors++; $display("FAIL single_pixels got=%0d required %0d", n_pix - p0, NPIX); end
    checks++; if (n_sof - s0 != 1) begin errors++; $display("FAIL single_sof got=%0d required 1", n_sof - s0); end
    checks++; if (n_eol - e0 != int'(V)) begin errors++; $display("FAIL single_eol got=%0d required %0d", n_eol - e0, V); end
    checks++; if (bus.avn_read !== 1'b0) begin errors++; $display("FAIL single_read_idle got=%b required 0", bus.avn_read); end
  endtask

  task automatic test_backpressure();
    int a0, p0, k;
    wait_pct = 0; rdy_pct = 0; lat_min = 1; lat_max = 1;
    a0 = n_acc; p0 = n_pix;
    @(negedge clk); enable = 1;
    @(negedge clk); enable = 0;
    repeat (30) @(negedge clk);
    checks++; if (n_acc - a0 != int'(BUF)) begin errors++; $display("FAIL bp_reads got=%0d required %0d", n_acc - a0, BUF); end
    checks++; if (bus.avn_read !== 1'b0) begin errors++; $display("FAIL bp_read got=%b required 0", bus.avn_read); end
    checks++; if (bus.pix_vld !== 1'b1) begin errors++; $display("FAIL bp_vld got=%b required 1", bus.pix_vld); end
    checks++; if (n_pix != p0) begin errors++; $display("FAIL bp_no_pop got=%0d required 0", n_pix - p0); end
    rdy_pct = 100;
    k = 0; while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got=%b required 0", busy); end
    checks++; if (n_pix - p0 != int'(NPIX) || n_acc - a0 != int'(NPIX)) begin errors++; $display("FAIL bp_counts pix=%0d reads=%0d required %0d", n_pix - p0, n_acc - a0, NPIX); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_sb_left got=%0d required 0", sb.size()); end
  endtask

  task automatic test_random();
    int p0, st0, k;
    wait_pct = 50; rdy_pct = 60; lat_min = 1; lat_max = 5;
    st0 = n_stall;
    for (int rep = 0; rep < 3; rep++) begin
      p0 = n_pix;
      @(negedge clk); enable = 1;
      @(negedge clk); enable = 0;
      k = 0; while (busy !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy_%0d got=%b required 0", rep, busy); end
      checks++; if (n_pix - p0 != int'(NPIX)) begin errors++; $display("FAIL rand_pixels_%0d got=%0d required %0d", rep, n_pix - p0, NPIX); end
    end
    checks++; if (n_stall == st0) begin errors++; $display("FAIL rand_stalls got=0 required >0"); end
    wait_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
  endtask

  task automatic test_back_to_back();
    int a0, p0, s0, k;
    wait_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    last_idx = 0; max_gap = 0;
    a0 = n_acc; p0 = n_pix; s0 = n_sof;
    @(negedge clk); enable = 1;
    k = 0; while (n_pix < p0 + 20 && k < 500) begin @(negedge clk); k++; end
    enable = 0;
    k = 0; while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b required 0", busy); end
    checks++; if (n_sof - s0 != 3) begin errors++; $display("FAIL b2b_sof got=%0d required 3", n_sof - s0); end
    checks++; if (n_pix - p0 != 3 * int'(NPIX) || n_acc - a0 != 3 * int'(NPIX)) begin errors++; $display("FAIL b2b_counts pix=%0d reads=%0d required %0d", n_pix - p0, n_acc - a0, 3 * NPIX); end
    checks++; if (max_gap < 1 || max_gap > int'(BUF) + 4) begin errors++; $display("FAIL b2b_wrap_gap got=%0d required 1..%0d", max_gap, BUF + 4); end
  endtask

  task automatic test_enable_drop();
    int a0, p0, s0, a1, k;
    wait_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    a0 = n_acc; p0 = n_pix; s0 = n_sof;
    @(negedge clk); enable = 1;
    k = 0; while (n_pix < p0 + 3 && k < 200) begin @(negedge clk); k++; end
    enable = 0;
    k = 0; while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    checks++; if (n_pix - p0 != int'(NPIX) || n_sof - s0 != 1) begin errors++; $display("FAIL drop_frame pix=%0d sof=%0d required %0d 1", n_pix - p0, n_sof - s0, NPIX); end
    a1 = n_acc;
    repeat (20) @(negedge clk);
    checks++; if (n_acc != a1 || a1 - a0 != int'(NPIX)) begin errors++; $display("FAIL drop_reads got=%0d required %0d", n_acc - a0, NPIX); end
    checks++; if (busy !== 1'b0 || bus.avn_read !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b read=%b required 0 0", busy, bus.avn_read); end
  endtask

  task automatic test_reset_mid_fetch();
    int a0, p0, s0, k;
    wait_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    a0 = n_acc;
    @(negedge clk); enable = 1;
    @(negedge clk); enable = 0;
    k = 0; while (n_acc < a0 + 3 && k < 50) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b required 1", busy); end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (bus.avn_read !== 1'b0 || bus.avn_address !== AW'(BASE)) begin errors++; $display("FAIL rst_async_req read=%b addr=%h required 0 %h", bus.avn_read, bus.avn_address, AW'(BASE)); end
    checks++; if (bus.pix_vld !== 1'b0 || bus.pix_sof !== 1'b0 || bus.pix_eol !== 1'b0) begin errors++; $display("FAIL rst_async_pix vld/sof/eol=%b%b%b required 000", bus.pix_vld, bus.pix_sof, bus.pix_eol); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b required 0", busy); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    acc_log.delete();
    p0 = n_pix; s0 = n_sof;
    @(negedge clk); enable = 1;
    @(negedge clk); enable = 0;
    k = 0; while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    checks++; if (acc_log.size() == 0 || acc_log[0] !== AW'(BASE)) begin errors++; $display("FAIL rst_restart_addr got=%h required %h", (acc_log.size() > 0) ? acc_log[0] : AW'(0), AW'(BASE)); end
    checks++; if (n_pix - p0 != int'(NPIX) || n_sof - s0 != 1) begin errors++; $display("FAIL rst_restart_frame pix=%0d sof=%0d required %0d 1", n_pix - p0, n_sof - s0, NPIX); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_sb_left got=%0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_fetch();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
